// File: rtl/ysyx_22040125_ifu_fetch.sv
// Instruction-fetch control: owns the PC, tracks the one-cycle RAM read latency and
// buffers returned {inst, pc} pairs in a small credit-managed FIFO towards decode.
module ysyx_22040125_ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          ADDR_W   = 16,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic [63:0]       cpu_pc,
   output logic [ADDR_W-1:0] addr,
   input  logic [31:0]       inst,
   input  logic [63:0]       if_pc,
   input  logic              redirect_valid,
   input  logic [63:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [63:0]       out_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [63:0]      pc_q, pc_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      mem_inst_q [DEPTH];
   logic [31:0]      mem_inst_d [DEPTH];
   logic [63:0]      mem_pc_q   [DEPTH];
   logic [63:0]      mem_pc_d   [DEPTH];

   logic             pop;
   logic             push;
   logic             issue;
   logic [CNT_W:0]   credit_used;

   assign cpu_pc    = pc_q;
   assign addr      = pc_q[ADDR_W+1:2];
   assign out_valid = (count_q != {CNT_W{1'b0}});
   assign out_inst  = mem_inst_q[rd_ptr_q];
   assign out_pc    = mem_pc_q[rd_ptr_q];

   // Credits count both buffered entries and the fetch still in the RAM pipe.
   always_comb begin
      pop         = out_valid & out_ready;
      push        = inflight_q & ~redirect_valid;
      credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
      issue       = ~rst & ~redirect_valid & (credit_used < DEPTH_C);

      pc_d       = pc_q;
      inflight_d = 1'b0;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect_valid) begin
         pc_d     = redirect_pc & ~64'h0000_0000_0000_0003;
         count_d  = {CNT_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
      end else begin
         if (issue) begin
            pc_d = pc_q + 64'd4;
         end else begin
            pc_d = pc_q;
         end
         inflight_d = issue;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO storage write port.
   always_comb begin
      mem_inst_d = mem_inst_q;
      mem_pc_d   = mem_pc_q;
      if (push) begin
         mem_inst_d[wr_ptr_q] = inst;
         mem_pc_d[wr_ptr_q]   = if_pc;
      end else begin
         mem_inst_d[wr_ptr_q] = mem_inst_q[wr_ptr_q];
         mem_pc_d[wr_ptr_q]   = mem_pc_q[wr_ptr_q];
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         count_q    <= {CNT_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Payload storage needs no reset: count gates its visibility.
   always_ff @(posedge clk) begin
      mem_inst_q <= mem_inst_d;
      mem_pc_q   <= mem_pc_d;
   end

endmodule

// File: tb/tb_ysyx_22040125_ifu_fetch.sv
// Directed bench for the fetch stage: RAM model, expected-stream scoreboard and a wrap instance.
module tb_ysyx_22040125_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic [63:0] cpu_pc, cpu_pc2, if_pc, if_pc2, redirect_pc, out_pc, out_pc2;
   logic [15:0] addr, addr2;
   logic [31:0] inst, inst2, out_inst, out_inst2;
   logic        redirect_valid, out_valid, out_valid2, out_ready;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];

   ysyx_22040125_ifu_fetch dut (
      .clk(clk), .rst(rst), .cpu_pc(cpu_pc), .addr(addr), .inst(inst), .if_pc(if_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
   );

   ysyx_22040125_ifu_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst2), .cpu_pc(cpu_pc2), .addr(addr2), .inst(inst2), .if_pc(if_pc2),
      .redirect_valid(1'b0), .redirect_pc(64'h0), .out_valid(out_valid2),
      .out_ready(1'b1), .out_inst(out_inst2), .out_pc(out_pc2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [63:0] pc);
      return 32'h0000_0013 + {16'h0000, pc[17:2]};
   endfunction

   // Synchronous RAM models: word k holds 0x13 + k.
   always @(posedge clk) begin
      inst   <= 32'h0000_0013 + {16'h0000, addr};
      if_pc  <= cpu_pc;
      inst2  <= 32'h0000_0013 + {16'h0000, addr2};
      if_pc2 <= cpu_pc2;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_stream(input logic [63:0] start);
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(start + 64'(4 * i));
   endtask

   // Every accepted handshake must match the next expected pair.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL unexpected_pop: observed pc %h expected none", out_pc);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("stream_pc", out_pc, e);
            chk("stream_inst", {32'h0, out_inst}, {32'h0, word_of(e)});
         end
      end
   end

   initial begin
      rst = 1'b1; rst2 = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 64'h0;

      // Reset state, then streaming.
      step(); step();
      chk("rst_cpu_pc", cpu_pc, 64'h8000_0000);
      chk("rst_addr", {48'h0, addr}, 64'h0);
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      expect_stream(64'h8000_0000);
      rst = 1'b0;
      step();
      chk("lat_valid_n1", {63'h0, out_valid}, 64'h0);
      step();
      chk("lat_valid_n2", {63'h0, out_valid}, 64'h1);
      chk("first_pc", out_pc, 64'h8000_0000);
      chk("first_inst", {32'h0, out_inst}, 64'h13);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("no_gap", {63'h0, out_valid}, 64'h1);
      end

      // Backpressure from the very first fetch.
      rst = 1'b1; out_ready = 1'b0;
      step(); step();
      expect_stream(64'h8000_0000);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("bp_addr", {48'h0, addr}, 64'h2);
      chk("bp_cpu_pc", cpu_pc, 64'h8000_0008);
      chk("bp_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_head_pc", out_pc, 64'h8000_0000);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      // Mid-stream reset with a full FIFO.
      out_ready = 1'b0;
      step(); step(); step();
      chk("full_valid", {63'h0, out_valid}, 64'h1);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
      chk("mid_rst_pc", cpu_pc, 64'h8000_0000);
      chk("mid_rst_addr", {48'h0, addr}, 64'h0);
      expect_stream(64'h8000_0000);
      rst = 1'b0;
      step(); step();
      chk("restart_pc", out_pc, 64'h8000_0000);
      chk("restart_inst", {32'h0, out_inst}, 64'h13);

      // Redirect with an entry buffered and a fetch in flight.
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0101;
      step();
      chk("redir_cpu_pc", cpu_pc, 64'h8000_0100);
      chk("redir_addr", {48'h0, addr}, 64'h40);
      chk("redir_flush", {63'h0, out_valid}, 64'h0);
      expect_stream(64'h8000_0100);
      redirect_valid = 1'b0;
      step();
      chk("redir_lat_n1", {63'h0, out_valid}, 64'h0);
      step();
      chk("redir_lat_n2", {63'h0, out_valid}, 64'h1);
      chk("redir_pc", out_pc, 64'h8000_0100);
      chk("redir_inst", {32'h0, out_inst}, 64'h53);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // Redirect coinciding with a pop, then a back-to-back redirect.
      chk("pre_pop_valid", {63'h0, out_valid}, 64'h1);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      step();
      chk("pop_redir_empty", {63'h0, out_valid}, 64'h0);
      chk("pop_redir_pc", cpu_pc, 64'h8000_0200);
      redirect_pc = 64'h8000_0400;
      step();
      chk("b2b_pc", cpu_pc, 64'h8000_0400);
      chk("b2b_empty", {63'h0, out_valid}, 64'h0);
      expect_stream(64'h8000_0400);
      redirect_valid = 1'b0;
      step(); step();
      chk("b2b_valid", {63'h0, out_valid}, 64'h1);
      chk("b2b_out_pc", out_pc, 64'h8000_0400);
      for (int i = 0; i < 4; i++) step();

      // PC wrap on the second instance.
      chk("wrap_rst_addr", {48'h0, addr2}, 64'hFFFE);
      rst2 = 1'b0;
      step();
      chk("wrap_addr1", {48'h0, addr2}, 64'hFFFF);
      chk("wrap_valid_n1", {63'h0, out_valid2}, 64'h0);
      step();
      chk("wrap_addr2", {48'h0, addr2}, 64'h0);
      chk("wrap_pc0", out_pc2, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_inst0", {32'h0, out_inst2}, 64'h1_0011);
      step();
      chk("wrap_addr3", {48'h0, addr2}, 64'h1);
      chk("wrap_pc1", out_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_inst1", {32'h0, out_inst2}, 64'h1_0012);
      step();
      chk("wrap_pc2", out_pc2, 64'h0);
      step();
      chk("wrap_pc3", out_pc2, 64'h4);
      chk("wrap_valid", {63'h0, out_valid2}, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
